// File: rtl/bec_op_sequencer.sv
// Word-serial operand loader, key feeder and result unloader for the binary-Edwards scalar-mult core.
// Optional RUN watchdog enabled by defining BEC_SEQ_TIMEOUT_EN.
module bec_op_sequencer #(
  parameter int DATA_W  = 163,
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 6,
  parameter int N_OPS   = 5
`ifdef BEC_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              abort,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  output logic              core_enable,
  output logic              core_load_data,
  output logic [2:0]        core_load_status,
  output logic [DATA_W-1:0] core_data_out,
  output logic              core_ki,
  input  logic              core_next_key,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_data_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_data,
  output logic              busy,
  output logic              done_o,
  output logic              key_ovr,
  output logic              err
);

  localparam int LO_W  = (N_WORDS - 1) * WORD_W;
  localparam int TOP_W = DATA_W - LO_W;
  localparam int PAD_W = N_WORDS * WORD_W - DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int WC_W  = $clog2(N_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRESENT, S_RUN, S_UNLOAD} state_t;

  state_t state, state_d;

  logic [N_WORDS-2:0][WORD_W-1:0] lo_words;
  logic [N_WORDS-1:0][WORD_W-1:0] res_words;
  logic [DATA_W-1:0]              key_sr;
  logic [DATA_W-1:0]              res_buf;
  logic [2:0]                     op_idx;
  logic [WC_W-1:0]                wcnt;
  logic [WC_W-1:0]                rcnt;
  logic [CNT_W-1:0]               bit_cnt;
  logic                           wr_fire, res_fire;
  logic                           last_word, last_op, last_res;
  logic                           timeout_hit;

  assign wr_fire   = wr_valid & wr_ready;
  assign res_fire  = res_valid & res_ready;
  assign last_word = (wcnt == WC_W'(N_WORDS - 1));
  assign last_res  = (rcnt == WC_W'(N_WORDS - 1));
  assign last_op   = (op_idx == 3'(N_OPS - 1));

  // Result viewed as host words; the top word carries only the TOP_W msbs, zero-extended.
  assign res_words = {{PAD_W{1'b0}}, res_buf};

`ifdef BEC_SEQ_TIMEOUT_EN
  logic [15:0] tcnt;
  assign timeout_hit = (tcnt == 16'(TIMEOUT_CYC - 1));

  // Counts completed RUN cycles; held at zero outside RUN so every RUN entry starts fresh.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i || abort || state != S_RUN) tcnt <= '0;
    else                                      tcnt <= tcnt + 16'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) state <= S_IDLE;
    else           state <= state_d;
  end

  always_comb begin
    state_d        = state;
    wr_ready       = 1'b0;
    res_valid      = 1'b0;
    core_enable    = 1'b0;
    core_load_data = 1'b0;
    case (state)
      S_IDLE:    if (start) state_d = S_LOAD;
      S_LOAD: begin
        wr_ready = 1'b1;
        if (wr_fire && last_word) state_d = last_op ? S_RUN : S_PRESENT;
      end
      S_PRESENT: begin
        core_load_data = 1'b1;
        state_d        = S_LOAD;
      end
      S_RUN: begin
        core_enable = 1'b1;
        if (core_done)        state_d = S_UNLOAD;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_UNLOAD: begin
        res_valid = 1'b1;
        if (res_ready && last_res) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  assign busy             = (state != S_IDLE);
  assign core_load_status = core_load_data ? op_idx : 3'd0;
  assign core_ki          = (state == S_RUN) & key_sr[DATA_W-1];
  assign res_data         = res_valid ? res_words[rcnt] : '0;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      lo_words      <= '0;
      key_sr        <= '0;
      res_buf       <= '0;
      core_data_out <= '0;
      op_idx        <= '0;
      wcnt          <= '0;
      rcnt          <= '0;
      bit_cnt       <= '0;
      done_o        <= 1'b0;
      key_ovr       <= 1'b0;
      err           <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort) begin
        op_idx  <= '0;
        wcnt    <= '0;
        rcnt    <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            op_idx  <= '0;
            wcnt    <= '0;
            key_ovr <= 1'b0;
            err     <= 1'b0;
          end
          S_LOAD: if (wr_fire) begin
            wcnt <= wcnt + 1'b1;
            if (!last_word) begin
              lo_words[wcnt] <= wr_data;
            end else if (last_op) begin
              // Last word goes straight into the assembled value; only its low TOP_W bits are operand bits.
              key_sr  <= {wr_data[TOP_W-1:0], lo_words};
              bit_cnt <= '0;
            end else begin
              core_data_out <= {wr_data[TOP_W-1:0], lo_words};
            end
          end
          S_PRESENT: begin
            op_idx <= op_idx + 3'd1;
            wcnt   <= '0;
          end
          S_RUN: begin
            if (core_next_key) begin
              key_sr <= {key_sr[DATA_W-2:0], 1'b0};
              if (bit_cnt == CNT_W'(DATA_W)) key_ovr <= 1'b1;
              else                           bit_cnt <= bit_cnt + 1'b1;
            end
            if (core_done) begin
              res_buf <= core_data_in;
              rcnt    <= '0;
            end else if (timeout_hit) begin
              err <= 1'b1;
            end
          end
          S_UNLOAD: if (res_fire) begin
            if (last_res) begin
              rcnt   <= '0;
              done_o <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/bec_op_sequencer.md
Name: bec_op_sequencer

Overview:
Word-serial front end and run sequencer for the binary-Edwards scalar-multiplication core.
- Takes 32-bit words from a host (Wishbone/LA glue) and assembles 163-bit operands.
- Presents each operand to the core with a load strobe and operand index, then holds the core enabled.
- Feeds scalar key bits one at a time on the core's next_key requests, and streams the 163-bit result back as 32-bit words.
- Sits between the host control logic and the core, in place of hand-driven configBus/ki sequencing.

Parameters:
DATA_W, 163, operand/result width in bits
WORD_W, 32, host word width
N_WORDS, 6, words per operand, equal to ceil(DATA_W/WORD_W)
N_OPS, 5, operands per job; indices 0..N_OPS-2 are core operands, index N_OPS-1 is the scalar key
TIMEOUT_CYC, 65535, watchdog limit in RUN (used only with the optional feature)

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  reset, synchronous, active-low
start  in  1  begin a job; sampled only in IDLE
abort  in  1  synchronous abort to IDLE
wr_valid  in  1  host word valid
wr_ready  out  1  sequencer accepts a word
wr_data  in  32  host word, least-significant word first
core_enable  out  1  core enable
core_load_data  out  1  one-cycle operand load strobe
core_load_status  out  3  index of the operand being loaded
core_data_out  out  163  operand bus to the core
core_ki  out  1  current key bit
core_next_key  in  1  core request for the next key bit (single-cycle pulse)
core_done  in  1  core finished
core_data_in  in  163  core result
res_valid  out  1  result word valid
res_ready  in  1  host accepts a result word
res_data  out  32  result word, least-significant word first
busy  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse when the last result word is accepted
key_ovr  out  1  sticky flag: key bits exhausted; cleared by start
err  out  1  sticky timeout flag; cleared by start

Behaviour:
- Reset (wb_rst_i=0 at a clock edge): state=IDLE; every output is 0, including core_data_out and the key shift register; all counters are 0.
- States: IDLE, LOAD, PRESENT, RUN, UNLOAD.
- IDLE:
  - start=1 -> LOAD; op_idx=0, wcnt=0; key_ovr and err cleared.
- LOAD:
  - wr_ready=1.
  - Each wr_valid&wr_ready stores wr_data into word slot wcnt and increments wcnt.
  - Word 5 contributes only bits [2:0] (operand bits 162:160); its upper 29 bits are ignored.
  - After the 6th word, if op_idx<N_OPS-1 -> PRESENT.
  - After the 6th word, if op_idx=N_OPS-1 -> the key is copied into the shift register, bit_cnt=0, and the state goes to RUN.
- PRESENT (exactly 1 cycle):
  - core_load_data=1, core_load_status=op_idx, core_data_out=assembled operand.
  - Next cycle: op_idx+1, wcnt=0, back to LOAD.
  - core_data_out holds its value until the next PRESENT.
- RUN:
  - core_enable=1 from the first RUN cycle.
  - core_ki = key_sr[162] (key consumed MSB first).
  - On core_next_key: key_sr shifts left one bit with 0 fill, and bit_cnt increments.
  - A core_next_key with bit_cnt=163 sets key_ovr; core_ki stays 0.
  - On core_done: core_data_in is captured, core_enable=0 next cycle, rcnt=0, -> UNLOAD.
  - If core_next_key and core_done arrive in the same cycle, the shift is applied and the done is honoured.
- UNLOAD:
  - res_valid=1; res_data = result word rcnt, where word 5 is zero-extended from 3 bits.
  - A handshake increments rcnt.
  - On the 6th handshake: done_o=1 for 1 cycle, -> IDLE.
  - res_data is stable while res_valid&!res_ready.
- Ignored inputs:
  - core_done outside RUN.
  - core_next_key outside RUN.
  - start outside IDLE.
- abort=1, any state: -> IDLE next cycle. core_enable, core_load_data, wr_ready and res_valid go to 0; counters clear; core_data_out and the sticky flags are retained.
- Reset has priority over abort; abort has priority over all other events.

Optional Feature:
BEC_SEQ_TIMEOUT_EN:
- Defined:
  - A 16-bit counter clears on entry to RUN and increments every RUN cycle.
  - When it reaches TIMEOUT_CYC without core_done: err=1, core_enable=0, -> IDLE; no result is unloaded and done_o is not pulsed.
- Undefined: no counter is built, RUN waits indefinitely, and err is tied to 0.

Test Plan:
- Basic job: start, then 30 words (op k word j = {k,j} pattern; key = 163'h4_0000...0001), core model asserts done 200 cycles after enable -> four PRESENT pulses with core_load_status 0,1,2,3, each with the exact 163-bit operand; ki sequence 1,0...0,1 over 163 requests; 6 result words, word 5 = core_data_in[162:160] zero-extended; one done_o pulse.
- Backpressure: wr_valid toggled randomly and res_ready low for 10 cycles mid-UNLOAD -> no word lost or duplicated, and res_data stable while stalled.
- Key overrun: core model issues 165 next_key pulses -> key_ovr=1 after the 164th, ki=0 for the last two, job still completes.
- Abort mid-RUN after 50 key bits -> IDLE next cycle, core_enable=0, busy=0; a following start/job runs cleanly with bit_cnt restarting at 0.
- Reset mid-LOAD (wb_rst_i=0 for 1 cycle after 3 words) -> all outputs 0; a new job needs the full 30 words.
- With BEC_SEQ_TIMEOUT_EN, TIMEOUT_CYC=100 and core_done never asserted -> err=1 at RUN cycle 100, IDLE, no res_valid, no done_o.
